// File: rtl/timer_display_pkg.sv
// Shared glyph and digit-index constants for the multiplexed m:ss display.
package timer_display_pkg;
  // Glyphs are {g,f,e,d,c,b,a}, active-high (lit = 1).
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [1:0] IDX_MIN = 2'd0;
  localparam logic [1:0] IDX_S1  = 2'd1;
  localparam logic [1:0] IDX_S0  = 2'd2;
endpackage

// File: rtl/timer_display_mux_seg7.sv
// BCD to active-high 7-segment glyph; non-BCD codes render as a dash.
module bcd_to_seg7
  import timer_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);
  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/timer_display_mux.sv
// 3-digit time-multiplexed 7-seg driver: per-frame snapshot, anti-ghost
// blanking after each digit change, and whole-display blink while paused.
module timer_display_mux
  import timer_display_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_HZ       = 2,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seconds0,
  input  logic [3:0] seconds1,
  input  logic [3:0] minutes0,
  input  logic       paused,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an
);
  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int HALF = SCAN_HZ / (2 * BLINK_HZ);
  localparam int PW   = $clog2(DIV);
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [PW-1:0] pres;
  logic [1:0]    idx;
  logic [BW-1:0] blank_cnt;
  logic [HW-1:0] blink_cnt;
  logic          blink_on;
  logic [3:0]    snap_m, snap_s1, snap_s0;
  logic          tick;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_glyph;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic [2:0]    an_r;

  assign tick = (pres == PW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pres      <= '0;
      idx       <= IDX_MIN;
      blank_cnt <= '0;
      snap_m    <= '0;
      snap_s1   <= '0;
      snap_s0   <= '0;
    end else begin
      pres <= tick ? '0 : pres + 1'b1;
      if (tick) begin
        blank_cnt <= BW'(BLANK_CYCLES);
        if (idx == IDX_S0) begin
          idx     <= IDX_MIN;
          snap_m  <= minutes0;
          snap_s1 <= seconds1;
          snap_s0 <= seconds0;
        end else begin
          idx <= idx + 2'd1;
        end
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

  // Pausing restarts from the visible phase; resuming forces visibility at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!paused) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == HW'(HALF - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = snap_m;
    case (idx)
      IDX_S1:  cur_digit = snap_s1;
      IDX_S0:  cur_digit = snap_s0;
      default: cur_digit = snap_m;
    endcase
  end

  bcd_to_seg7 u_dec (.bcd(cur_digit), .glyph(cur_glyph));

  // Active-high internal image; polarity is applied only at the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r <= '0;
      dp_r  <= 1'b0;
      an_r  <= '0;
    end else if (blank_cnt != '0 || !blink_on) begin
      seg_r <= '0;
      dp_r  <= 1'b0;
      an_r  <= '0;
    end else begin
      seg_r <= cur_glyph;
      dp_r  <= (idx == IDX_MIN);
      an_r  <= 3'b100 >> idx;
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_r  : dp_r;
  assign an  = AN_ACTIVE_LOW  ? ~an_r  : an_r;
endmodule

// File: tb/tb_timer_display_mux.sv
// Randomized and directed bench against a cycle-count based reference model.
module tb_timer_display_mux;
  localparam int CLK_HZ = 1000, SCAN_HZ = 250, BLINK_HZ = 25, BLANK = 1;
  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int HALF = SCAN_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s0 = 4'd0, s1 = 4'd0, m0 = 4'd0;
  logic       paused = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] an;

  int n_total = 0, n_pass = 0, n_fail = 0;

  // Model: e = edges since reset release, pt = ticks seen while continuously paused.
  int e = 0, pt = 0;
  int snap [3] = '{0, 0, 0};
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [2:0] exp_an;

  timer_display_mux #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ),
    .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .seconds0(s0), .seconds1(s1), .minutes0(m0),
    .paused(paused), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic int cur_idx();
    return (e / DIV) % 3;
  endfunction

  function automatic bit visible();
    bit blanking = (e >= DIV) && ((e % DIV) < BLANK);
    return !blanking && ((pt / HALF) % 2 == 0);
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      e = 0; pt = 0; snap = '{0, 0, 0};
      exp_an = 3'b111; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      if (visible()) begin
        exp_an  = ~(3'b100 >> cur_idx());
        exp_seg = ~glyph(snap[cur_idx()]);
        exp_dp  = !(cur_idx() == 0);
      end else begin
        exp_an = 3'b111; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      e++;
      if (e % DIV == 0 && cur_idx() == 0)
        snap = '{int'(m0), int'(s1), int'(s0)};
      pt = paused ? pt + ((e % DIV == 0) ? 1 : 0) : 0;
    end
    #1;
    chk("an", {4'b0, an}, {4'b0, exp_an});
    chk("seg", seg, exp_seg);
    chk("dp", {6'b0, dp}, {6'b0, exp_dp});
    chk("one_anode", 7'($countones(~an) <= 1), 7'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset and first capture on the 3rd tick.
    run(3);
    reset = 1'b0;
    m0 = 4'd3; s1 = 4'd4; s0 = 4'd7;
    run(3 * DIV * 3);

    // Asynchronous reset mid-slot blanks the outputs without a clock edge.
    run(2);
    reset = 1'b1;
    #1;
    chk("rst_async_an", {4'b0, an}, 7'h07);
    chk("rst_async_seg", seg, 7'h7F);
    chk("rst_async_dp", {6'b0, dp}, 7'h01);
    run(2);
    reset = 1'b0;
    run(3 * DIV * 2);

    // Frame coherence: 0:59 -> 1:00 while the tens digit is on screen.
    m0 = 4'd0; s1 = 4'd5; s0 = 4'd9;
    run(3 * DIV * 2);
    for (int i = 0; i < 3 * DIV && cur_idx() != 1; i++) step();
    step();
    m0 = 4'd1; s1 = 4'd0; s0 = 4'd0;
    run(3 * DIV * 2);

    // Invalid BCD shows a dash.
    s0 = 4'hC;
    run(3 * DIV * 2);

    // Blink for 30 ticks, then resume while blanked.
    paused = 1'b1;
    run(30 * DIV);
    for (int i = 0; i < 20 * DIV && visible(); i++) step();
    chk("blink_reached_dark", 7'(visible()), 7'd0);
    paused = 1'b0;
    run(3 * DIV);

    // Randomized inputs and pause toggling.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        m0 = 4'($urandom_range(0, 15));
        s1 = 4'($urandom_range(0, 15));
        s0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 39) == 0) paused = ~paused;
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      else reset = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
